// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: the pipeline writeback has priority; MDU results queue in an
// in-order FIFO and drain into idle cycles, with kill-on-overwrite and a starvation stall.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    input  logic [31:0] mdu_pc,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    output logic        pend_hit1,
    output logic        pend_hit2,
    output logic        wb_stall,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_data,
    output logic [31:0] grf_pc
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [4:0]       e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [31:0]      e_pc   [DEPTH];
    logic [DEPTH-1:0] e_live;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] starve_cnt;

    logic pipe_act, head_valid, head_live, grant_head, pop, push, store, any_live;
    logic hit1, hit2;

    always_comb begin
        pipe_act   = wb_we && (wb_addr != 5'd0);
        head_valid = (count != '0);
        head_live  = head_valid && e_live[rd_ptr];
        grant_head = !pipe_act && head_live;
        // A dead head is discarded every cycle, whether or not the pipeline writes.
        pop        = head_valid && (!e_live[rd_ptr] || grant_head);
        mdu_ready  = !reset && (count != FULL_CNT);
        push       = mdu_valid && mdu_ready;
        store      = push && (mdu_addr != 5'd0);
        any_live   = |e_live;
    end

    always_comb begin
        grf_we   = 1'b0;
        grf_addr = '0;
        grf_data = '0;
        grf_pc   = '0;
        if (!reset) begin
            if (pipe_act) begin
                grf_we   = 1'b1;
                grf_addr = wb_addr;
                grf_data = wb_data;
                grf_pc   = wb_pc;
            end else if (head_live) begin
                grf_we   = 1'b1;
                grf_addr = e_addr[rd_ptr];
                grf_data = e_data[rd_ptr];
                grf_pc   = e_pc[rd_ptr];
            end
        end
    end

    // Live bits are cleared on pop and reset, so only in-window slots can match.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (e_live[i] && (e_addr[i] == rd_a1)) hit1 = 1'b1;
            if (e_live[i] && (e_addr[i] == rd_a2)) hit2 = 1'b1;
        end
        pend_hit1 = !reset && (rd_a1 != 5'd0) && hit1;
        pend_hit2 = !reset && (rd_a2 != 5'd0) && hit2;
        wb_stall  = !reset && (starve_cnt == STARVE_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            e_live <= '0;
        end else begin
            if (pipe_act) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (e_addr[AW'(i)] == wb_addr) e_live[AW'(i)] <= 1'b0;
                end
            end
            if (pop) begin
                e_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + AW'(1);
            end
            // Same-cycle enqueue lands after the kill so the younger MDU result survives.
            if (store) begin
                e_addr[wr_ptr] <= mdu_addr;
                e_data[wr_ptr] <= mdu_data;
                e_pc[wr_ptr]   <= mdu_pc;
                e_live[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (store && !pop)      count <= count + (AW + 1)'(1);
            else if (!store && pop) count <= count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (head_live && pipe_act) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + CW'(1);
        end else if (grant_head || !any_live) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port between two requesters: the pipeline W-stage writeback and a long-latency multiply/divide unit (MDU) result path.
- The pipeline always has priority. MDU results wait in a small in-order FIFO and drain into idle write-port cycles.
- Also provides pending-write indicators for the hazard unit, and a starvation stall request.
- Sits between the W stage, the MDU and the GRF write inputs (RegWrite, RegAddr, RegData, PC).

Parameters:
- DEPTH, 4, MDU FIFO entries; power of two, at least 2.
- STARVE_MAX, 8, consecutive denied cycles before a stall is requested; at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_we  input  1  pipeline writeback request.
- wb_addr  input  5  pipeline destination register.
- wb_data  input  32  pipeline write data.
- wb_pc  input  32  PC of the pipeline instruction.
- mdu_valid  input  1  MDU result valid.
- mdu_ready  output  1  FIFO can accept a result; equals !full.
- mdu_addr  input  5  MDU destination register.
- mdu_data  input  32  MDU result.
- mdu_pc  input  32  PC of the MDU instruction.
- rd_a1  input  5  hazard-unit lookup address 1.
- rd_a2  input  5  hazard-unit lookup address 2.
- pend_hit1  output  1  a live FIFO entry targets rd_a1.
- pend_hit2  output  1  a live FIFO entry targets rd_a2.
- wb_stall  output  1  starvation stall request to the hazard unit.
- grf_we  output  1  to GRF RegWrite.
- grf_addr  output  5  to GRF RegAddr.
- grf_data  output  32  to GRF RegData.
- grf_pc  output  32  to GRF PC.

Behaviour:
- Reset:
  - Count, pointers, all entry live bits and starve_cnt are cleared.
  - While reset=1, grf_we=0, pend_hit*=0, wb_stall=0 and mdu_ready=0.
  - After reset: mdu_ready=1; grf_addr, grf_data and grf_pc are 0.
  - Reset asserted mid-operation discards all buffered entries; none are written.
- The grf_* outputs are combinational, so the GRF captures the write at the same edge.
- Grant rule:
  - pipe_act = wb_we && wb_addr != 0.
  - If pipe_act, the grf_* outputs carry the wb_* values.
  - Otherwise, if the head entry is live, the grf_* outputs carry the head entry and it is popped.
  - Otherwise grf_we=0 and the grf_* data outputs are 0.
- Enqueue:
  - Occurs on mdu_valid && mdu_ready.
  - mdu_addr==0: the handshake completes but nothing is stored.
  - Otherwise {addr, data, pc, live=1} is stored at the tail.
  - mdu_ready is derived from the registered count, so full means no enqueue, even if a pop occurs that cycle.
- Dead-entry pop: a non-live head is popped every cycle without writing, regardless of pipe_act.
- Kill:
  - When pipe_act, every existing entry whose addr equals wb_addr has live cleared at the edge.
  - This prevents an older MDU result overwriting a newer pipeline value.
  - An entry being enqueued in the same cycle is not killed; the MDU result is treated as younger.
- Simultaneous pop and enqueue in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Pending lookup:
  - pend_hitN = 1 if any live entry has addr == rd_aN and rd_aN != 0.
  - The lookup is combinational and covers current state only, not same-cycle enqueues.
- Starvation counter (starve_cnt):
  - Increments, saturating at STARVE_MAX, when the head is live and pipe_act=1.
  - Clears when the head is granted or the FIFO is empty of live entries.
  - wb_stall = (starve_cnt == STARVE_MAX).
  - The hazard unit then bubbles W (wb_we=0). The next cycle grants the head and clears the counter.
- Write ordering to the GRF equals grant order; at most one write per cycle.

Test Plan:
- Reset, then 3 MDU pushes {$3=0x11, $4=0x22, $5=0x33} with wb_we=0 -> grf_we on 3 consecutive cycles, writing $3, $4, $5 in order; mdu_ready stays 1.
- FIFO full (4 entries) while pipeline writes $8 for 4 cycles -> mdu_ready=0 and no enqueue on a further mdu_valid; grf_addr=8 each cycle; FIFO drains once wb_we=0.
- FIFO holds $6=0xAA; pipeline writes $6=0xBB -> pend_hit1(rd_a1=6) drops to 0 next cycle; entry popped dead; final $6=0xBB; no grf_we for 0xAA.
- mdu_addr=0 push -> handshake completes, count stays 0, no GRF write; wb_we with wb_addr=0 lets a live head drain that cycle.
- Pipeline writes continuously with 1 live entry, STARVE_MAX=8 -> wb_stall=1 after 8 cycles; wb_we=0 for one cycle -> head written, wb_stall=0 the following cycle.
- Reset asserted with 2 live entries -> no writes during or after reset; pend_hit*=0; mdu_ready=1 once reset is released.
